mtl_wipe_display: RTL and testbench

Downstream MTL LCD front-end for the SDRAM memory management unit. Generates 800x480 panel timing on iCLK_33 and drives the two read FIFOs (image 1 = current, image 2 = next). Muxes the two pixel streams into a horizontal wipe transition on a west gesture. Emits the frame markers, FIFO resync, and image-advance requests that the MMU consumes.

---
 rtl/mtl_wipe_display.sv | 192 +++++++++++++++++++
 tb/tb_mtl_wipe_display.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mtl_wipe_display.sv
// MTL LCD front-end: panel timing, lockstep reads of two image FIFOs, and a horizontal wipe
// between them driven by touch gestures, plus the frame/resync/advance markers for the MMU.
module mtl_wipe_display #(
  parameter int unsigned H_SYNC     = 30,
  parameter int unsigned H_BP       = 16,
  parameter int unsigned H_ACT      = 800,
  parameter int unsigned H_FP       = 210,
  parameter int unsigned V_SYNC     = 13,
  parameter int unsigned V_BP       = 10,
  parameter int unsigned V_ACT      = 480,
  parameter int unsigned V_FP       = 22,
  parameter int unsigned SLIDE_STEP = 32,
  parameter logic [23:0] LOAD_RGB   = 24'h202020
) (
  input  logic        iCLK_33,
  input  logic        iRST,
  input  logic        iLoading,
  input  logic        iTouch_W,
  input  logic        iTouch_E,
  input  logic [31:0] iRead_Data1,
  input  logic [31:0] iRead_Data2,
  output logic        oRead_En1,
  output logic        oRead_En2,
  output logic        oNew_Frame,
  output logic        oEnd_Frame,
  output logic        oRd_RST,
  output logic        oGest_W,
  output logic        oGest_E,
  output logic        oHSD,
  output logic        oVSD,
  output logic        oDE,
  output logic [7:0]  oR,
  output logic [7:0]  oG,
  output logic [7:0]  oB
);

  localparam int unsigned H_TOT   = H_SYNC + H_BP + H_ACT + H_FP;
  localparam int unsigned V_TOT   = V_SYNC + V_BP + V_ACT + V_FP;
  localparam int unsigned H_ACT_S = H_SYNC + H_BP;
  localparam int unsigned H_ACT_E = H_ACT_S + H_ACT;
  localparam int unsigned V_ACT_S = V_SYNC + V_BP;
  localparam int unsigned V_ACT_E = V_ACT_S + V_ACT;
  localparam int unsigned HW      = $clog2(H_TOT);
  localparam int unsigned VW      = $clog2(V_TOT);
  localparam logic [9:0]  STEP    = 10'(SLIDE_STEP);
  localparam logic [9:0]  SPLIT_0 = 10'(H_ACT);

  typedef enum logic [1:0] {StIdle, StWipe, StHold, StPendE} state_e;

  logic [HW-1:0] h_q;
  logic [VW-1:0] v_q;
  logic          h_act, v_act, rd_en, eof;
  logic [9:0]    x;
  logic          act_d1, hs_d1, vs_d1;
  logic [9:0]    x_d1;
  logic [23:0]   pix;
  state_e        state_q, state_d;
  logic [9:0]    split_q, split_d, split_dec;
  logic          load_q, arm_q, arm_d;
  logic          unused_hi;

  assign unused_hi = ^{iRead_Data1[31:24], iRead_Data2[31:24]};

  always_ff @(posedge iCLK_33 or posedge iRST) begin
    if (iRST) begin
      h_q <= '0;
      v_q <= '0;
    end else if (h_q == HW'(H_TOT - 1)) begin
      h_q <= '0;
      v_q <= (v_q == VW'(V_TOT - 1)) ? '0 : v_q + VW'(1);
    end else begin
      h_q <= h_q + HW'(1);
    end
  end

  assign h_act      = (h_q >= HW'(H_ACT_S)) && (h_q < HW'(H_ACT_E));
  assign v_act      = (v_q >= VW'(V_ACT_S)) && (v_q < VW'(V_ACT_E));
  assign rd_en      = h_act && v_act;
  assign x          = 10'(h_q - HW'(H_ACT_S));
  assign eof        = (h_q == '0) && (v_q == VW'(V_ACT_E));
  assign oRead_En1  = rd_en;
  assign oRead_En2  = rd_en;
  // Counters sit at 0,0 throughout reset; keep the frame marker quiet until release.
  assign oNew_Frame = (h_q == '0) && (v_q == '0) && !iRST;
  assign oEnd_Frame = eof;
  assign oRd_RST    = arm_q && eof;

  always_comb begin
    pix = '0;
    if (act_d1) begin
      if (iLoading) begin
        pix = LOAD_RGB;
      end else if (x_d1 >= split_q) begin
        pix = iRead_Data2[23:0];
      end else begin
        pix = iRead_Data1[23:0];
      end
    end
  end

  always_ff @(posedge iCLK_33 or posedge iRST) begin
    if (iRST) begin
      act_d1       <= 1'b0;
      hs_d1        <= 1'b1;
      vs_d1        <= 1'b1;
      x_d1         <= '0;
      oDE          <= 1'b0;
      oHSD         <= 1'b1;
      oVSD         <= 1'b1;
      {oR, oG, oB} <= '0;
    end else begin
      act_d1       <= rd_en;
      hs_d1        <= !(h_q < HW'(H_SYNC));
      vs_d1        <= !(v_q < VW'(V_SYNC));
      x_d1         <= x;
      oDE          <= act_d1;
      oHSD         <= hs_d1;
      oVSD         <= vs_d1;
      {oR, oG, oB} <= pix;
    end
  end

  assign split_dec = (split_q > STEP) ? split_q - STEP : '0;

  // A gesture is latched into the state as soon as it arrives; all split updates and
  // advance requests then happen on frame-end cycles.
  always_comb begin
    state_d = state_q;
    split_d = split_q;
    oGest_W = 1'b0;
    oGest_E = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!iLoading) begin
          if (iTouch_W) begin
            state_d = StWipe;
          end else if (iTouch_E) begin
            state_d = StPendE;
          end
        end
      end
      StWipe: begin
        if (eof) begin
          split_d = split_dec;
          if (split_dec == '0) begin
            oGest_W = 1'b1;
            state_d = StHold;
          end
        end
      end
      StHold: begin
        if (eof) begin
          split_d = SPLIT_0;
          state_d = StIdle;
        end
      end
      StPendE: begin
        if (eof) begin
          oGest_E = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    arm_d = arm_q;
    if (iLoading && !load_q) begin
      arm_d = 1'b0;
    end else if (!iLoading && load_q) begin
      arm_d = 1'b1;
    end else if (eof) begin
      arm_d = 1'b0;
    end
  end

  always_ff @(posedge iCLK_33 or posedge iRST) begin
    if (iRST) begin
      state_q <= StIdle;
      split_q <= SPLIT_0;
      load_q  <= 1'b0;
      arm_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      split_q <= split_d;
      load_q  <= iLoading;
      arm_q   <= arm_d;
    end
  end

endmodule

// File: tb/tb_mtl_wipe_display.sv
// Bench for mtl_wipe_display on a shrunken panel: random pixel data and gestures checked
// every cycle against a frame-level model computed from counter arithmetic.
module tb_mtl_wipe_display;

  localparam int H_SYNC = 3, H_BP = 2, H_ACT = 16, H_FP = 3;
  localparam int V_SYNC = 2, V_BP = 1, V_ACT = 4, V_FP = 2;
  localparam int STEP = 5;
  localparam logic [23:0] LOAD = 24'h202020;
  localparam int HT = H_SYNC + H_BP + H_ACT + H_FP;
  localparam int VT = V_SYNC + V_BP + V_ACT + V_FP;
  localparam int FR = HT * VT;

  logic        iCLK_33 = 1'b0, iRST = 1'b1, iLoading = 1'b0, iTouch_W = 1'b0, iTouch_E = 1'b0;
  logic [31:0] iRead_Data1 = '0, iRead_Data2 = '0;
  logic        oRead_En1, oRead_En2, oNew_Frame, oEnd_Frame, oRd_RST, oGest_W, oGest_E;
  logic        oHSD, oVSD, oDE;
  logic [7:0]  oR, oG, oB;

  mtl_wipe_display #(
    .H_SYNC(H_SYNC), .H_BP(H_BP), .H_ACT(H_ACT), .H_FP(H_FP),
    .V_SYNC(V_SYNC), .V_BP(V_BP), .V_ACT(V_ACT), .V_FP(V_FP),
    .SLIDE_STEP(STEP), .LOAD_RGB(LOAD)
  ) dut (
    .iCLK_33(iCLK_33), .iRST(iRST), .iLoading(iLoading), .iTouch_W(iTouch_W),
    .iTouch_E(iTouch_E), .iRead_Data1(iRead_Data1), .iRead_Data2(iRead_Data2),
    .oRead_En1(oRead_En1), .oRead_En2(oRead_En2), .oNew_Frame(oNew_Frame),
    .oEnd_Frame(oEnd_Frame), .oRd_RST(oRd_RST), .oGest_W(oGest_W), .oGest_E(oGest_E),
    .oHSD(oHSD), .oVSD(oVSD), .oDE(oDE), .oR(oR), .oG(oG), .oB(oB)
  );

  always #5 iCLK_33 = ~iCLK_33;

  typedef struct {
    bit          act;
    bit          hs;
    bit          vs;
    int          x;
    logic [23:0] d1;
    logic [23:0] d2;
    bit          load;
    int          split;
  } ent_t;

  int   errors = 0, checks = 0;
  int   cyc, m_split, rd_cnt, de_cnt;
  bit   wiping, holding, pend_e, armed, prev_load, seen_sof;
  ent_t p1, p2;
  int   cnt_gw, cnt_ge, cnt_rst;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_reset();
    ent_t r;
    r = '{act: 0, hs: 1, vs: 1, x: 0, d1: '0, d2: '0, load: 0, split: H_ACT};
    p1 = r; p2 = r;
    cyc = 0; m_split = H_ACT; wiping = 0; holding = 0; pend_e = 0;
    armed = 0; prev_load = 0; seen_sof = 0; rd_cnt = 0; de_cnt = 0;
  endtask

  task automatic check_reset_vals();
    chk("rst_hsd", 32'(oHSD), 1);
    chk("rst_vsd", 32'(oVSD), 1);
    chk("rst_de", 32'(oDE), 0);
    chk("rst_rgb", {8'h0, oR, oG, oB}, 0);
    chk("rst_rden", {30'h0, oRead_En1, oRead_En2}, 0);
    chk("rst_frame", {30'h0, oNew_Frame, oEnd_Frame}, 0);
    chk("rst_pulses", {29'h0, oRd_RST, oGest_W, oGest_E}, 0);
    chk("rst_split", 32'(dut.split_q), H_ACT);
  endtask

  // One pixel clock: drive inputs, compare mid-cycle, advance the model, step the clock.
  task automatic cyc_step(input bit tw, input bit te);
    int h, v, nxt;
    bit act, sof, eof, accept;
    logic [23:0] exp_rgb;
    ent_t cur;
    iTouch_W = tw;
    iTouch_E = te;
    iRead_Data1 = $urandom() & 32'h00FF_FFFF;
    iRead_Data2 = $urandom() & 32'h00FF_FFFF;
    @(negedge iCLK_33);
    h   = cyc % HT;
    v   = (cyc / HT) % VT;
    act = (h >= H_SYNC + H_BP) && (h < H_SYNC + H_BP + H_ACT) &&
          (v >= V_SYNC + V_BP) && (v < V_SYNC + V_BP + V_ACT);
    sof = (h == 0) && (v == 0);
    eof = (h == 0) && (v == V_SYNC + V_BP + V_ACT);
    nxt = (m_split > STEP) ? m_split - STEP : 0;
    chk("rd_en1", 32'(oRead_En1), 32'(act));
    chk("rd_en2", 32'(oRead_En2), 32'(act));
    chk("new_frame", 32'(oNew_Frame), 32'(sof));
    chk("end_frame", 32'(oEnd_Frame), 32'(eof));
    chk("rd_rst", 32'(oRd_RST), 32'(armed && eof));
    chk("gest_w", 32'(oGest_W), 32'(wiping && eof && nxt == 0));
    chk("gest_e", 32'(oGest_E), 32'(pend_e && eof));
    chk("hsd", 32'(oHSD), 32'(p2.hs));
    chk("vsd", 32'(oVSD), 32'(p2.vs));
    chk("de", 32'(oDE), 32'(p2.act));
    if (!p2.act) exp_rgb = '0;
    else if (p1.load) exp_rgb = LOAD;
    else if (p2.x >= p1.split) exp_rgb = p1.d2;
    else exp_rgb = p1.d1;
    chk("rgb", {8'h0, oR, oG, oB}, {8'h0, exp_rgb});
    chk("split", 32'(dut.split_q), 32'(m_split));
    if (sof) begin
      if (seen_sof) begin
        chk("reads_per_frame", rd_cnt, H_ACT * V_ACT);
        chk("de_per_frame", de_cnt, H_ACT * V_ACT);
      end
      seen_sof = 1; rd_cnt = 0; de_cnt = 0;
    end
    rd_cnt += int'(oRead_En1);
    de_cnt += int'(oDE);
    cnt_gw += int'(oGest_W);
    cnt_ge += int'(oGest_E);
    cnt_rst += int'(oRd_RST);
    cur = '{act: act, hs: (h >= H_SYNC), vs: (v >= V_SYNC), x: h - (H_SYNC + H_BP),
            d1: iRead_Data1[23:0], d2: iRead_Data2[23:0], load: iLoading, split: m_split};
    p2 = p1;
    p1 = cur;
    accept = !wiping && !holding && !pend_e && !iLoading;
    if (eof) begin
      if (wiping) begin
        m_split = nxt;
        if (m_split == 0) begin wiping = 0; holding = 1; end
      end else if (holding) begin
        m_split = H_ACT; holding = 0;
      end else if (pend_e) begin
        pend_e = 0;
      end
    end
    if (accept) begin
      if (tw) wiping = 1;
      else if (te) pend_e = 1;
    end
    if (iLoading && !prev_load) armed = 0;
    else if (!iLoading && prev_load) armed = 1;
    else if (eof) armed = 0;
    prev_load = iLoading;
    @(posedge iCLK_33);
    #1;
    cyc++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc_step(0, 0);
  endtask

  initial begin
    bit ok;
    model_reset();
    repeat (3) @(posedge iCLK_33);
    @(negedge iCLK_33);
    check_reset_vals();
    @(posedge iCLK_33);
    #1;
    iRST = 1'b0;
    model_reset();

    // Free run: timing, frame totals, image-1 latency.
    run(2 * FR);

    // West wipe with an east gesture dropped mid-way.
    cnt_gw = 0; cnt_ge = 0;
    cyc_step(1, 0);
    run(2 * FR);
    cyc_step(0, 1);
    run(4 * FR);
    chk("wipe_gest_w_count", cnt_gw, 1);
    chk("wipe_gest_e_dropped", cnt_ge, 0);

    // East gesture from idle.
    cnt_gw = 0; cnt_ge = 0;
    cyc_step(0, 1);
    run(2 * FR);
    chk("east_gest_e_count", cnt_ge, 1);
    chk("east_gest_w_count", cnt_gw, 0);

    // Simultaneous gestures: west wins.
    cnt_gw = 0; cnt_ge = 0;
    cyc_step(1, 1);
    run(6 * FR);
    chk("both_gest_w_count", cnt_gw, 1);
    chk("both_gest_e_count", cnt_ge, 0);

    // Loading: fill colour, gestures ignored, resync on the following frame end.
    cnt_gw = 0; cnt_ge = 0; cnt_rst = 0;
    iLoading = 1'b1;
    run(30);
    cyc_step(1, 0);
    run(100);
    cyc_step(0, 1);
    run(FR);
    ok = 0;
    for (int i = 0; i < FR && !ok; i++) begin
      if (cyc % FR == 100) ok = 1;
      else cyc_step(0, 0);
    end
    chk("load_drop_point_reached", 32'(ok), 1);
    iLoading = 1'b0;
    run(2 * FR);
    chk("load_gest_ignored", cnt_gw + cnt_ge, 0);
    chk("load_rd_rst_count", cnt_rst, 1);

    // Random gestures and loading toggles.
    for (int i = 0; i < 10 * FR; i++) begin
      if ($urandom_range(0, 399) == 0) iLoading = ~iLoading;
      cyc_step($urandom_range(0, 99) == 0, $urandom_range(0, 99) == 0);
    end
    iLoading = 1'b0;

    // Reset in the middle of a wipe.
    for (int i = 0; i < 20 * FR && (wiping || holding || pend_e); i++) cyc_step(0, 0);
    chk("idle_before_reset_test", {29'h0, wiping, holding, pend_e}, 0);
    cyc_step(1, 0);
    for (int i = 0; i < 10 * FR && m_split != H_ACT - 2 * STEP; i++) cyc_step(0, 0);
    chk("wipe_mid_split_reached", 32'(m_split), H_ACT - 2 * STEP);
    run(50);
    iRST = 1'b1;
    cnt_gw = 0; cnt_ge = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge iCLK_33);
      check_reset_vals();
      cnt_gw += int'(oGest_W);
      @(posedge iCLK_33);
      #1;
    end
    iRST = 1'b0;
    model_reset();
    run(3 * FR);
    chk("post_reset_no_gest", cnt_gw + cnt_ge, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
